// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : Parametrised VGA-style raster timing generator. Produces a
//             one-clk pixel enable from the system clock, h/v counters, sync,
//             blank and line/frame start markers, all cycle-aligned with the
//             counters they describe.
//  Option   : define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter
//             output (frame_count).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             pix_ce,
   output logic [CNT_W-1:0] hcounter,
   output logic [CNT_W-1:0] vcounter,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_count
`endif
);

   localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]   c_h_last   = CNT_W'(c_h_total - 1);
   localparam logic [CNT_W-1:0]   c_v_last   = CNT_W'(c_v_total - 1);
   localparam logic [CNT_W-1:0]   c_h_act    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0]   c_v_act    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0]   c_hs_start = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0]   c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0]   c_vs_start = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0]   c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic               c_h_on     = (H_POL != 0);
   localparam logic               c_v_on     = (V_POL != 0);

   // Refuse to elaborate a timing set the counters or divider cannot represent.
   generate
      if ((CLK_DIV < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
          (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1) ||
          (((c_h_total - 1) >> CNT_W) != 0) ||
          (((c_v_total - 1) >> CNT_W) != 0)) begin : g_param_check
         $error("vga_timing_gen: illegal parameter set (CLK_DIV, porch/sync width or CNT_W)");
      end
   endgenerate

   logic [c_div_w-1:0] r_div;
   logic [CNT_W-1:0]   r_hcnt;
   logic [CNT_W-1:0]   r_vcnt;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_blank;
   logic               r_line_start;
   logic               r_frame_start;

   logic               w_pix_ce;
   logic               w_h_wrap;
   logic               w_v_wrap;
   logic [CNT_W-1:0]   w_h_next;
   logic [CNT_W-1:0]   w_v_next;

   // Pixel enable is high for the last divider phase while running; it is
   // kept combinational in en so that CLK_DIV=1 yields pix_ce == en.
   assign w_pix_ce = en & ~rst & (r_div == c_div_last);

   // Next raster position; the line counter only steps on a horizontal wrap.
   always_comb begin
      w_h_wrap = (r_hcnt == c_h_last);
      w_v_wrap = (r_vcnt == c_v_last);
      w_h_next = w_h_wrap ? '0 : r_hcnt + CNT_W'(1);
      w_v_next = r_vcnt;
      if (w_h_wrap) begin
         w_v_next = w_v_wrap ? '0 : r_vcnt + CNT_W'(1);
      end
   end

   // Clock divider: counts enabled clks, restarts from 0 whenever en drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
      end else if (!en || (r_div == c_div_last)) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + c_div_w'(1);
      end
   end

   // Counters and decoded markers advance together, decoded from the next
   // position so every marker lines up with the counter value it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hcnt        <= '0;
         r_vcnt        <= '0;
         r_hsync       <= ~c_h_on;
         r_vsync       <= ~c_v_on;
         r_blank       <= 1'b0;
         r_line_start  <= 1'b1;
         r_frame_start <= 1'b1;
      end else if (w_pix_ce) begin
         r_hcnt        <= w_h_next;
         r_vcnt        <= w_v_next;
         r_hsync       <= ((w_h_next >= c_hs_start) && (w_h_next < c_hs_end)) ? c_h_on : ~c_h_on;
         r_vsync       <= ((w_v_next >= c_vs_start) && (w_v_next < c_vs_end)) ? c_v_on : ~c_v_on;
         r_blank       <= (w_h_next >= c_h_act) || (w_v_next >= c_v_act);
         r_line_start  <= (w_h_next == '0);
         r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Frame counter steps in the pixel period that returns the raster to (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (w_pix_ce && w_h_wrap && w_v_wrap) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign frame_count = r_frame_cnt;
`endif

   assign pix_ce      = w_pix_ce;
   assign hcounter    = r_hcnt;
   assign vcounter    = r_vcnt;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign blank       = r_blank;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Brief    : Self-checking bench for vga_timing_gen. Two instances (a small
//             divided raster and an undivided one) run from shared random
//             en/rst stimulus and are compared each clk against a reference
//             model expressed in pixel-count arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   // Instance A: divided clock, small raster, active-high vsync
   localparam int A_DIV = 3;
   localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
   localparam int A_VA = 5, A_VF = 1, A_VS = 2, A_VB = 1;
   localparam int A_HP = 0, A_VP = 1, A_W = 5;
   // Instance B: undivided clock, active-high hsync, tight counter width
   localparam int B_DIV = 1;
   localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
   localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
   localparam int B_HP = 1, B_VP = 0, B_W = 4;

   typedef struct packed {
      logic [31:0] h;
      logic [31:0] v;
      logic        hs;
      logic        vs;
      logic        bl;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   logic           a_ce, a_hs, a_vs, a_bl, a_ls, a_fs;
   logic [A_W-1:0] a_h, a_v;
   logic           b_ce, b_hs, b_vs, b_bl, b_ls, b_fs;
   logic [B_W-1:0] b_h, b_v;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0]    a_fc, b_fc;
`endif

   int n_checks = 0;
   int n_errors = 0;
   // Model state: pixel periods elapsed since reset, en-high clks in streak
   int p_a = 0, run_a = 0, p_b = 0, run_b = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .H_POL(A_HP), .V_POL(A_VP), .CNT_W(A_W)
   ) u_dut_a (
      .clk(clk), .rst(rst), .en(en), .pix_ce(a_ce),
      .hcounter(a_h), .vcounter(a_v), .hsync(a_hs), .vsync(a_vs),
      .blank(a_bl), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_count(a_fc)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .H_POL(B_HP), .V_POL(B_VP), .CNT_W(B_W)
   ) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .pix_ce(b_ce),
      .hcounter(b_h), .vcounter(b_v), .hsync(b_hs), .vsync(b_vs),
      .blank(b_bl), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_count(b_fc)
`endif
   );

   // Raster position and decoded signals after p pixel periods
   function automatic exp_t model(input int p, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs,
                                  input int vb, input int hp, input int vp);
      exp_t e;
      int   ht, vt, h, v;
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      h    = p % ht;
      v    = (p / ht) % vt;
      e.h  = 32'(h);
      e.v  = 32'(v);
      e.hs = ((h >= ha + hf) && (h < ha + hf + hs)) ? (hp != 0) : (hp == 0);
      e.vs = ((v >= va + vf) && (v < va + vf + vs)) ? (vp != 0) : (vp == 0);
      e.bl = (h >= ha) || (v >= va);
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
      e.fc = 16'((p / (ht * vt)) % 65536);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic do_checks();
      exp_t ea, eb;
      ea = model(p_a, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP);
      eb = model(p_b, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_HP, B_VP);
      check("a_pix_ce", 32'(a_ce), 32'(en && !rst && ((run_a % A_DIV) == A_DIV - 1)));
      check("a_hcounter", 32'(a_h), ea.h);
      check("a_vcounter", 32'(a_v), ea.v);
      check("a_hsync", 32'(a_hs), 32'(ea.hs));
      check("a_vsync", 32'(a_vs), 32'(ea.vs));
      check("a_blank", 32'(a_bl), 32'(ea.bl));
      check("a_line_start", 32'(a_ls), 32'(ea.ls));
      check("a_frame_start", 32'(a_fs), 32'(ea.fs));
      check("b_pix_ce", 32'(b_ce), 32'(en && !rst && ((run_b % B_DIV) == B_DIV - 1)));
      check("b_hcounter", 32'(b_h), eb.h);
      check("b_vcounter", 32'(b_v), eb.v);
      check("b_hsync", 32'(b_hs), 32'(eb.hs));
      check("b_vsync", 32'(b_vs), 32'(eb.vs));
      check("b_blank", 32'(b_bl), 32'(eb.bl));
      check("b_line_start", 32'(b_ls), 32'(eb.ls));
      check("b_frame_start", 32'(b_fs), 32'(eb.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("a_frame_count", 32'(a_fc), 32'(ea.fc));
      check("b_frame_count", 32'(b_fc), 32'(eb.fc));
`endif
   endtask

   // Drive inputs on the falling edge, check, then advance the model at the rising edge
   task automatic step(input logic en_v, input logic rst_v);
      logic ce_a, ce_b;
      @(negedge clk);
      en  = en_v;
      rst = rst_v;
      #1;
      do_checks();
      ce_a = en && !rst && ((run_a % A_DIV) == A_DIV - 1);
      ce_b = en && !rst && ((run_b % B_DIV) == B_DIV - 1);
      @(posedge clk);
      if (rst) begin
         p_a = 0; run_a = 0; p_b = 0; run_b = 0;
      end else begin
         if (ce_a) p_a++;
         if (ce_b) p_b++;
         run_a = en ? run_a + 1 : 0;
         run_b = en ? run_b + 1 : 0;
      end
   endtask

   initial begin
      @(posedge clk);
      // Reset state, including pix_ce held low while en=1 under reset
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      // Free-running for more than two frames of instance A
      repeat (900) step(1'b1, 1'b0);
      // Pause: everything must hold, then the divider restarts from zero
      repeat (10) step(1'b0, 1'b0);
      repeat (12) step(1'b1, 1'b0);
      // Random run enable, mostly high with short gaps
      repeat (3000) step(($urandom_range(0, 7) != 0), 1'b0);
      // Asynchronous reset between edges: values must change without a clock
      @(negedge clk);
      en = 1'b1;
      #2;
      rst = 1'b1;
      p_a = 0; run_a = 0; p_b = 0; run_b = 0;
      #1;
      do_checks();
      step(1'b1, 1'b1);
      // Restart from (0,0) and run on with random enable
      repeat (200) step(1'b1, 1'b0);
      repeat (600) step(($urandom_range(0, 5) != 0), 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
